// File: rtl/fp_stream_accumulator.sv
// Streaming front-end that folds each valid/ready packet of single-precision operands into one sum,
// plus the combinational single-precision adder it drives.

module comb_fp_summator (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        vld_i,
    output logic [31:0] answer_o,
    output logic [1:0]  answer_status_o
);

    logic        big_sign;
    logic        small_sign;
    logic [7:0]  big_exp;
    logic [7:0]  small_exp;
    logic [22:0] big_mant;
    logic [22:0] small_mant;
    logic [7:0]  exp_diff;
    logic [23:0] big_sig;
    logic [23:0] small_sig;
    logic [24:0] small_shifted;
    logic [24:0] add_sum;
    logic [23:0] sub_diff;
    logic [23:0] norm_sig;
    logic [4:0]  lead_zeros;
    logic        lz_found;
    logic [31:0] result;

    // Order operands by magnitude so alignment and subtraction never go negative;
    // denormals are flushed to zero and results are truncated, not rounded.
    always_comb begin
        if (a_i[30:0] >= b_i[30:0]) begin
            big_sign   = a_i[31];
            big_exp    = a_i[30:23];
            big_mant   = a_i[22:0];
            small_sign = b_i[31];
            small_exp  = b_i[30:23];
            small_mant = b_i[22:0];
        end else begin
            big_sign   = b_i[31];
            big_exp    = b_i[30:23];
            big_mant   = b_i[22:0];
            small_sign = a_i[31];
            small_exp  = a_i[30:23];
            small_mant = a_i[22:0];
        end

        big_sig       = (big_exp == 8'd0)   ? 24'd0 : {1'b1, big_mant};
        small_sig     = (small_exp == 8'd0) ? 24'd0 : {1'b1, small_mant};
        exp_diff      = big_exp - small_exp;
        small_shifted = (exp_diff > 8'd24) ? 25'd0 : ({1'b0, small_sig} >> exp_diff);
        add_sum       = {1'b0, big_sig} + small_shifted;
        sub_diff      = big_sig - small_shifted[23:0];

        lead_zeros = 5'd0;
        lz_found   = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found && sub_diff[i]) begin
                lead_zeros = 5'(23 - i);
                lz_found   = 1'b1;
            end
        end
        norm_sig = sub_diff << lead_zeros;

        result = 32'd0;
        if (big_exp == 8'hFF) begin
            result = {big_sign, big_exp, big_mant};
        end else if (big_sign == small_sign) begin
            if (add_sum[24]) begin
                if (big_exp == 8'hFE)
                    result = {big_sign, 8'hFF, 23'd0};
                else
                    result = {big_sign, big_exp + 8'd1, add_sum[23:1]};
            end else begin
                result = {big_sign, big_exp, add_sum[22:0]};
            end
        end else if (lz_found && (big_exp > {3'b000, lead_zeros})) begin
            result = {big_sign, big_exp - {3'b000, lead_zeros}, norm_sig[22:0]};
        end

        answer_o        = vld_i ? result : 32'd0;
        answer_status_o = {vld_i & (result[30:23] == 8'hFF), vld_i & (result[30:0] == 31'd0)};
    end

endmodule

module fp_stream_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             s_vld_i,
    input  logic [31:0]      s_data_i,
    input  logic             s_last_i,
    output logic             s_rdy_o,
    output logic             m_vld_o,
    output logic [31:0]      m_data_o,
    output logic [CNT_W-1:0] m_cnt_o,
    output logic             m_ovf_o,
    input  logic             m_rdy_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    state_t            state;
    logic [31:0]       acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              beat;
    logic [31:0]       sum;
    logic [31:0]       acc_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_nxt;

    assign s_rdy_o = (state != OUT);
    assign beat    = s_vld_i && s_rdy_o;

    comb_fp_summator u_summator (
        .a_i             (acc),
        .b_i             (s_data_i),
        .vld_i           (beat),
        .answer_o        (sum),
        .answer_status_o ()
    );

    // The first beat of a packet loads the accumulator directly instead of adding to zero.
    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (state == IDLE) begin
            acc_nxt = s_data_i;
            cnt_nxt = CNT_W'(1);
            ovf_nxt = (s_data_i[30:23] == 8'hFF);
        end else begin
            acc_nxt = sum;
            cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
            ovf_nxt = ovf | (s_data_i[30:23] == 8'hFF) | (sum[30:23] == 8'hFF);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            acc      <= 32'd0;
            cnt      <= '0;
            ovf      <= 1'b0;
            m_vld_o  <= 1'b0;
            m_data_o <= 32'd0;
            m_cnt_o  <= '0;
            m_ovf_o  <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (beat) begin
                        acc <= acc_nxt;
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (s_last_i) begin
                            state    <= OUT;
                            m_vld_o  <= 1'b1;
                            m_data_o <= acc_nxt;
                            m_cnt_o  <= cnt_nxt;
                            m_ovf_o  <= ovf_nxt;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                OUT: begin
                    if (m_rdy_i) begin
                        state   <= IDLE;
                        m_vld_o <= 1'b0;
                        acc     <= 32'd0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
